// File: rtl/gen192_sendtime_sendesc.sv
// ============================================================================
// gen192_sendtime_sendesc : legal 192-bit control-word source (IDLE/ESC runs + SYNC on request)
// Optional stall checker: define GEN192_STALL_CHK_EN.                rev 1.0
// ============================================================================
`default_nettype none

`ifndef ESC_CHAR
`define ESC_CHAR  48'h1b1b_1b1b_1b1b
`endif
`ifndef IDLE_CHAR
`define IDLE_CHAR 48'h0707_0707_0707
`endif
`ifndef SYNC_CHAR
`define SYNC_CHAR 37'h1a_5a5a_c3c3
`endif

module gen192_sendtime_sendesc #(
   parameter int IDLE_GAP  = 8,
   parameter int ESC_BURST = 2,
   parameter int STALL_MAX = 1000
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en,
   input  logic         full,
   input  logic         sendtime,
   output logic         push,
   output logic [191:0] data,
   output logic [15:0]  sync_cnt,
   output logic         stall_err
);

   localparam logic [191:0] IDLE_W    = {4{`IDLE_CHAR}};
   localparam logic [191:0] ESC_W     = {4{`ESC_CHAR}};
   localparam logic [191:0] SYNC_W    = {4{{`SYNC_CHAR, 11'h0}}};
   localparam logic [10:0]  IDLE_LAST = 11'(IDLE_GAP - 1);
   localparam logic [10:0]  ESC_LAST  = 11'(ESC_BURST - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ESC  = 2'd1,
      S_SYNC = 2'd2
   } state_t;

   state_t         state_q, state_d;
   state_t         saved_q, saved_d;
   state_t         run_next;
   logic [10:0]    run_cnt_q, run_cnt_d, run_cnt_nxt;
   logic           sync_pend_q, sync_pend_d;
   logic [15:0]    sync_cnt_q, sync_cnt_d;
   logic [191:0]   data_q, data_d;

   function automatic logic [191:0] word_of(input state_t s);
      case (s)
         S_ESC:   word_of = ESC_W;
         S_SYNC:  word_of = SYNC_W;
         default: word_of = IDLE_W;
      endcase
   endfunction

   assign push = en & ~full & reset_n;

   always_comb begin
      state_d     = state_q;
      saved_d     = saved_q;
      run_cnt_d   = run_cnt_q;
      sync_pend_d = sync_pend_q | sendtime;
      sync_cnt_d  = sync_cnt_q;
      data_d      = data_q;
      run_next    = state_q;
      run_cnt_nxt = run_cnt_q;

      // Where the current run goes after one more accepted word.
      case (state_q)
         S_IDLE: begin
            if (run_cnt_q == IDLE_LAST) begin
               run_cnt_nxt = 11'd0;
               run_next    = S_ESC;
            end else begin
               run_cnt_nxt = run_cnt_q + 11'd1;
            end
         end
         S_ESC: begin
            if (run_cnt_q == ESC_LAST) begin
               run_cnt_nxt = 11'd0;
               run_next    = S_IDLE;
            end else begin
               run_cnt_nxt = run_cnt_q + 11'd1;
            end
         end
         default: run_next = saved_q;
      endcase

      if (push) begin
         sync_pend_d = 1'b0;
         if (state_q == S_SYNC) begin
            sync_cnt_d = sync_cnt_q + 16'd1;
         end else begin
            run_cnt_d = run_cnt_nxt;
         end
         if (sync_pend_q | sendtime) begin
            state_d = S_SYNC;
            saved_d = run_next;
         end else begin
            state_d = run_next;
         end
         data_d = word_of(state_d);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         saved_q     <= S_IDLE;
         run_cnt_q   <= 11'd0;
         sync_pend_q <= 1'b0;
         sync_cnt_q  <= 16'd0;
         data_q      <= IDLE_W;
      end else begin
         state_q     <= state_d;
         saved_q     <= saved_d;
         run_cnt_q   <= run_cnt_d;
         sync_pend_q <= sync_pend_d;
         sync_cnt_q  <= sync_cnt_d;
         data_q      <= data_d;
      end
   end

   assign data     = data_q;
   assign sync_cnt = sync_cnt_q;

`ifdef GEN192_STALL_CHK_EN
   localparam logic [10:0] STALL_LIM = 11'(STALL_MAX);

   logic [10:0] stall_cnt_q, stall_cnt_d;
   logic        stall_err_q, stall_err_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (push || !en) begin
         stall_cnt_d = 11'd0;
      end else if (full && (stall_cnt_q != STALL_LIM)) begin
         stall_cnt_d = stall_cnt_q + 11'd1;
      end
      stall_err_d = (stall_cnt_d == STALL_LIM);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= 11'd0;
         stall_err_q <= 1'b0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         stall_err_q <= stall_err_d;
      end
   end

   assign stall_err = stall_err_q;
`else
   assign stall_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gen192_sendtime_sendesc.sv
// ============================================================================
// tb_gen192_sendtime_sendesc : scoreboard bench for the IDLE/ESC/SYNC word source
// rev 1.0
// ============================================================================
`default_nettype none

`ifndef ESC_CHAR
`define ESC_CHAR  48'h1b1b_1b1b_1b1b
`endif
`ifndef IDLE_CHAR
`define IDLE_CHAR 48'h0707_0707_0707
`endif
`ifndef SYNC_CHAR
`define SYNC_CHAR 37'h1a_5a5a_c3c3
`endif

module tb_gen192_sendtime_sendesc;

   localparam int IDLE_GAP  = 8;
   localparam int ESC_BURST = 2;
   localparam int STALL_MAX = 1000;
   localparam int PERIOD    = IDLE_GAP + ESC_BURST;

   localparam logic [191:0] IDLE_W = {4{`IDLE_CHAR}};
   localparam logic [191:0] ESC_W  = {4{`ESC_CHAR}};
   localparam logic [191:0] SYNC_W = {4{{`SYNC_CHAR, 11'h0}}};

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         en = 1'b0;
   logic         full = 1'b0;
   logic         sendtime = 1'b0;
   logic         push;
   logic [191:0] data;
   logic [15:0]  sync_cnt;
   logic         stall_err;

   gen192_sendtime_sendesc #(
      .IDLE_GAP (IDLE_GAP),
      .ESC_BURST(ESC_BURST),
      .STALL_MAX(STALL_MAX)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (en),
      .full     (full),
      .sendtime (sendtime),
      .push     (push),
      .data     (data),
      .sync_cnt (sync_cnt),
      .stall_err(stall_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: position within the IDLE/ESC period, plus SYNC flags.
   int   m_pos   = 0;
   bit   m_sync  = 1'b0;
   bit   m_pend  = 1'b0;
   int   m_sc    = 0;
   int   m_blk   = 0;
   bit   exp_push = 1'b0;
   logic [191:0] expq[$];

   function automatic logic [191:0] model_word();
      if (m_sync) return SYNC_W;
      return (m_pos < IDLE_GAP) ? IDLE_W : ESC_W;
   endfunction

   function automatic bit model_err();
`ifdef GEN192_STALL_CHK_EN
      return m_blk >= STALL_MAX;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic legal(input logic [191:0] w);
      return (w == IDLE_W) || (w == ESC_W) || (w == SYNC_W);
   endfunction

   task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Called at posedge+1: apply inputs, predict, advance past one edge, check.
   task automatic step(input bit e, input bit f, input bit s);
      bit acc;
      en = e; full = f; sendtime = s;
      acc = e && !f;
      exp_push = acc;
      if (acc) begin
         expq.push_back(model_word());
         if (m_sync) m_sc++;
         else        m_pos = (m_pos + 1) % PERIOD;
         m_sync = m_pend || s;
         m_pend = 1'b0;
      end else if (s) begin
         m_pend = 1'b1;
      end
      if (e && f) begin
         if (m_blk < STALL_MAX) m_blk++;
      end else begin
         m_blk = 0;
      end
      @(posedge clk); #1;
      chk("sync_cnt", 192'(sync_cnt), 192'(16'(m_sc)));
      chk("stall_err", 192'(stall_err), 192'(model_err()));
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      en = 1'b0; full = 1'b0; sendtime = 1'b0;
      exp_push = 1'b0;
      m_pos = 0; m_sync = 1'b0; m_pend = 1'b0; m_sc = 0; m_blk = 0;
      #1;
      chk("rst_data", data, IDLE_W);
      chk("rst_sync_cnt", 192'(sync_cnt), 192'(0));
      chk("rst_push", 192'(push), 192'(0));
      chk("rst_stall_err", 192'(stall_err), 192'(0));
      repeat (2) begin @(posedge clk); #1; end
      reset_n = 1'b1;
   endtask

   always @(negedge clk) begin
      chk("push", 192'(push), 192'(exp_push));
      if (push === 1'b1) begin
         if (expq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL data: push with no expected word, got %h", data);
         end else begin
            chk("data", data, expq.pop_front());
            chk("legal", 192'(legal(data)), 192'(1));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk); #1;
      do_reset();

      // Free run: 8 IDLE, 2 ESC, repeating.
      repeat (30) step(1, 0, 0);

      // One-clock sendtime during the 4th IDLE word.
      do_reset();
      repeat (3) step(1, 0, 0);
      step(1, 0, 1);
      repeat (12) step(1, 0, 0);

      // Sendtime held while blocked: collapses to one SYNC.
      repeat (5) step(1, 1, 1);
      repeat (12) step(1, 0, 0);

      // Long blockage.
      repeat (STALL_MAX + 5) step(1, 1, 0);
      repeat (3) step(1, 0, 0);

      // Reset while in SYNC with another request pending.
      step(1, 0, 1);
      step(1, 1, 1);
      do_reset();
      repeat (12) step(1, 0, 0);

      // Randomized traffic.
      for (int i = 0; i < 10000; i++) begin
         step($urandom_range(0, 9) != 0,
              $urandom_range(0, 99) < 30,
              $urandom_range(0, 99) < 8);
      end

      en = 1'b0; full = 1'b0; sendtime = 1'b0; exp_push = 1'b0;
      @(posedge clk); #1;
      chk("queue_empty", 192'(expq.size()), 192'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
